// File: rtl/reg_file_sb_pkg.sv
// Shared definitions for the rysy integer register file.
//   REG_LEN      : default register data width
//   REG_ADDR_LEN : default register address width (depth = 2**REG_ADDR_LEN)
//   rf_state_t   : clear-engine state (sweeping the array, or serving traffic)
package reg_file_sb_pkg;

  localparam int REG_LEN      = 32;
  localparam int REG_ADDR_LEN = 5;

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback-facing bus of the register file.
//   rd_addr/rd_data/rd_busy : NUM_RD packed read ports (port i at slice i)
//   wr_en/wr_addr/wr_data   : single writeback port
//   claim_en/claim_addr     : mark a destination register as pending
//   ready                   : clear finished, writes and claims accepted
// master = decode/writeback side, slave = register file.
interface reg_file_sb_if
  import reg_file_sb_pkg::*;
#(
  parameter int XLEN     = REG_LEN,
  parameter int ADDR_LEN = REG_ADDR_LEN,
  parameter int NUM_RD   = 2
) ();

  logic [NUM_RD*ADDR_LEN-1:0] rd_addr;
  logic [NUM_RD*XLEN-1:0]     rd_data;
  logic [NUM_RD-1:0]          rd_busy;
  logic                       wr_en;
  logic [ADDR_LEN-1:0]        wr_addr;
  logic [XLEN-1:0]            wr_data;
  logic                       claim_en;
  logic [ADDR_LEN-1:0]        claim_addr;
  logic                       ready;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    input  rd_data, rd_busy, ready
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    output rd_data, rd_busy, ready
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
//   clk, rst_n          : clock, async active-low reset (clears all busy bits)
//   active              : file is ready and out of reset; gates updates and outputs
//   wr_en/wr_addr       : writeback retires the pending write
//   claim_en/claim_addr : issue marks the destination pending
//   rd_addr/rd_busy     : NUM_RD lookup ports
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int ADDR_LEN = REG_ADDR_LEN,
  parameter int NUM_RD   = 2,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       active,
  input  logic                       wr_en,
  input  logic [ADDR_LEN-1:0]        wr_addr,
  input  logic                       claim_en,
  input  logic [ADDR_LEN-1:0]        claim_addr,
  input  logic [NUM_RD*ADDR_LEN-1:0] rd_addr,
  output logic [NUM_RD-1:0]          rd_busy
);

  localparam int DEPTH = 2**ADDR_LEN;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic             wr_hit, claim_hit;

  // Address 0 is hardwired: it can never become busy.
  assign wr_hit    = active && wr_en    && (wr_addr    != '0);
  assign claim_hit = active && claim_en && (claim_addr != '0);

  // Claim is applied after the write so a newer producer stays outstanding.
  always_comb begin
    busy_d = busy_q;
    if (wr_hit)    busy_d[wr_addr]    = 1'b0;
    if (claim_hit) busy_d[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_lookup
      logic [ADDR_LEN-1:0] addr;
      logic                byp_clr;
      assign addr = rd_addr[gi*ADDR_LEN +: ADDR_LEN];
      // A same-cycle write hides the busy bit, unless the same cycle re-claims it.
      assign byp_clr = BYPASS && wr_hit && (wr_addr == addr) &&
                       !(claim_hit && (claim_addr == addr));
      assign rd_busy[gi] = active && busy_q[addr] && !byp_clr;
    end
  endgenerate

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised integer register file with N read ports, optional write-to-read
// bypass, pending-write scoreboard and a post-reset clear engine.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (array itself is not reset)
//   bus   : reg_file_sb_if slave modport (read ports, write port, claims, ready)
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int XLEN           = REG_LEN,
  parameter int ADDR_LEN       = REG_ADDR_LEN,
  parameter int NUM_RD         = 2,
  parameter bit BYPASS         = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_sb_if.slave bus
);

  localparam int                  DEPTH     = 2**ADDR_LEN;
  localparam logic [ADDR_LEN-1:0] ONE       = ADDR_LEN'(1);
  localparam logic [ADDR_LEN-1:0] LAST_ADDR = ADDR_LEN'(DEPTH-1);
  localparam rf_state_t           RST_STATE = CLEAR_ON_RESET ? RF_CLEAR : RF_READY;

  rf_state_t           state_q, state_d;
  logic [ADDR_LEN-1:0] cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic [XLEN-1:0]     mem [DEPTH];

  logic                active;
  logic                wr_ok;
  logic [NUM_RD-1:0]   busy_w;

  // Everything outside the clear engine is masked while in reset or clearing.
  assign active = ready_q && rst_n;
  assign wr_ok  = active && bus.wr_en && (bus.wr_addr != '0);

  // Clear engine: walks x1..x(DEPTH-1); the counter saturates on the last entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    if (state_q == RF_CLEAR) begin
      if (cnt_q == LAST_ADDR) begin
        state_d = RF_READY;
        ready_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= ONE;
      ready_q <= ~CLEAR_ON_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Storage: no reset, single write port shared by clear engine and writeback.
  always_ff @(posedge clk) begin
    if (state_q == RF_CLEAR) mem[cnt_q]       <= '0;
    else if (wr_ok)          mem[bus.wr_addr] <= bus.wr_data;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_LEN-1:0] addr;
      logic                hit;
      assign addr = bus.rd_addr[gi*ADDR_LEN +: ADDR_LEN];
      assign hit  = BYPASS && wr_ok && (bus.wr_addr == addr);
      assign bus.rd_data[gi*XLEN +: XLEN] = (!active || addr == '0) ? '0 :
                                            hit ? bus.wr_data : mem[addr];
    end
  endgenerate

  reg_scoreboard #(
    .ADDR_LEN (ADDR_LEN),
    .NUM_RD   (NUM_RD),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .active     (active),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .claim_en   (bus.claim_en),
    .claim_addr (bus.claim_addr),
    .rd_addr    (bus.rd_addr),
    .rd_busy    (busy_w)
  );

  assign bus.rd_busy = busy_w;
  assign bus.ready   = ready_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances (bypass on / bypass off) share stimulus;
// expected read results are queued when inputs are driven and drained at negedge.
module tb_reg_file_sb;

  localparam int XL = 32;
  localparam int AL = 5;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR*AL-1:0] rd_addr;
  logic          wr_en;
  logic [AL-1:0] wr_addr;
  logic [XL-1:0] wr_data;
  logic          claim_en;
  logic [AL-1:0] claim_addr;

  always #5 clk = ~clk;

  reg_file_sb_if #(.XLEN(XL), .ADDR_LEN(AL), .NUM_RD(NR)) if_a ();
  reg_file_sb_if #(.XLEN(XL), .ADDR_LEN(AL), .NUM_RD(NR)) if_b ();

  assign if_a.rd_addr    = rd_addr;
  assign if_a.wr_en      = wr_en;
  assign if_a.wr_addr    = wr_addr;
  assign if_a.wr_data    = wr_data;
  assign if_a.claim_en   = claim_en;
  assign if_a.claim_addr = claim_addr;
  assign if_b.rd_addr    = rd_addr;
  assign if_b.wr_en      = wr_en;
  assign if_b.wr_addr    = wr_addr;
  assign if_b.wr_data    = wr_data;
  assign if_b.claim_en   = claim_en;
  assign if_b.claim_addr = claim_addr;

  reg_file_sb #(.XLEN(XL), .ADDR_LEN(AL), .NUM_RD(NR), .BYPASS(1'b1), .CLEAR_ON_RESET(1'b1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  reg_file_sb #(.XLEN(XL), .ADDR_LEN(AL), .NUM_RD(NR), .BYPASS(1'b0), .CLEAR_ON_RESET(1'b1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  // Reference model
  logic [XL-1:0] m_mem [32];
  logic          m_busy [32];
  bit            m_ready;

  typedef struct {
    string         tag;
    int            dut;
    int            port;
    logic [XL-1:0] data;
    logic          busy;
  } exp_t;
  exp_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [XL-1:0] act, input logic [XL-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  function automatic logic [XL-1:0] exp_data(input bit byp, input logic [AL-1:0] a);
    if (!m_ready || a == 0) return '0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [AL-1:0] a);
    logic b;
    if (!m_ready) return 1'b0;
    b = m_busy[a];
    if (byp && wr_en && wr_addr == a && a != 0 && !(claim_en && claim_addr == a)) b = 1'b0;
    return b;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  task automatic push_reads(input string tag);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NR; p++) begin
        exp_t e;
        logic [AL-1:0] a;
        a = rd_addr[p*AL +: AL];
        e.tag  = tag;
        e.dut  = d;
        e.port = p;
        e.data = exp_data(d == 0, a);
        e.busy = exp_busy(d == 0, a);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [XL-1:0] ad;
      logic          ab;
      e  = exp_q.pop_front();
      ad = (e.dut == 0) ? if_a.rd_data[e.port*XL +: XL] : if_b.rd_data[e.port*XL +: XL];
      ab = (e.dut == 0) ? if_a.rd_busy[e.port] : if_b.rd_busy[e.port];
      chk($sformatf("%s.%s.p%0d.data", e.tag, (e.dut == 0) ? "byp" : "nobyp", e.port), ad, e.data);
      chk($sformatf("%s.%s.p%0d.busy", e.tag, (e.dut == 0) ? "byp" : "nobyp", e.port), 32'(ab), 32'(e.busy));
    end
  endtask

  // One transaction: queue expectations, compare at negedge, apply the edge to the model.
  task automatic cycle(input string tag);
    push_reads(tag);
    @(negedge clk);
    drain();
    $display("txn %-14s rd=%0d,%0d wr=%b@%0d=%h claim=%b@%0d",
             tag, rd_addr[AL-1:0], rd_addr[2*AL-1:AL], wr_en, wr_addr, wr_data, claim_en, claim_addr);
    @(posedge clk);
    if (m_ready) begin
      if (wr_en && wr_addr != 0) begin
        m_mem[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (claim_en && claim_addr != 0) m_busy[claim_addr] = 1'b1;
    end
    #1;
    wr_en    = 1'b0;
    claim_en = 1'b0;
  endtask

  // Entered at a negedge just after rst_n release; ready must rise on edge 31 exactly.
  task automatic run_clear(input string tag, input bit stray);
    for (int e = 1; e <= 31; e++) begin
      @(posedge clk);
      #1;
      if (e == 31) m_ready = 1'b1;
      chk($sformatf("%s.ready_byp.e%0d", tag, e), 32'(if_a.ready), 32'(e == 31));
      chk($sformatf("%s.ready_nobyp.e%0d", tag, e), 32'(if_b.ready), 32'(e == 31));
      if (stray && e == 9) begin
        // Counter is 10 here: traffic during clear must be ignored.
        rd_addr    = {5'd20, 5'd20};
        wr_en      = 1'b1;
        wr_addr    = 5'd20;
        wr_data    = 32'hFFFF_FFFF;
        claim_en   = 1'b1;
        claim_addr = 5'd20;
        #1;
        chk({tag, ".clr_rd_gated"}, if_a.rd_data[XL-1:0], '0);
        chk({tag, ".clr_busy_gated"}, 32'(if_a.rd_busy[0]), '0);
      end
      if (stray && e == 10) begin
        wr_en    = 1'b0;
        claim_en = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    claim_en = 1'b0; claim_addr = '0;
    m_ready = 1'b0;
    model_clear();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", 32'(if_a.ready), '0);
    chk("rst.rd_data", if_a.rd_data[XL-1:0], '0);
    chk("rst.rd_busy", 32'(if_a.rd_busy), '0);
    rst_n = 1'b1;
    run_clear("clr1", 1'b1);

    // Whole array reads zero; x20 untouched by the stray traffic.
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      cycle($sformatf("sweep%0d", a));
    end

    // Bypass: same-cycle visibility only on the bypass instance.
    rd_addr = {5'd0, 5'd5};
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    #1;
    chk("byp.same_cycle", if_a.rd_data[XL-1:0], 32'hDEAD_BEEF);
    chk("nobyp.same_cycle", if_b.rd_data[XL-1:0], 32'h0);
    cycle("wr5");
    cycle("wr5_after");

    // x0 is hardwired.
    rd_addr = {5'd0, 5'd0};
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
    claim_en = 1'b1; claim_addr = 5'd0;
    cycle("x0_wr_claim");
    cycle("x0_after");

    // Claim then retire x7.
    rd_addr = {5'd9, 5'd7};
    claim_en = 1'b1; claim_addr = 5'd7;
    cycle("claim7");
    cycle("claim7_after");
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
    cycle("wr7");
    cycle("wr7_after");

    // Same-cycle claim and write on x9: claim wins, data lands.
    claim_en = 1'b1; claim_addr = 5'd9;
    cycle("claim9");
    claim_en = 1'b1; claim_addr = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hB5B5_B5B5;
    cycle("claimwr9");
    cycle("claimwr9_after");
    chk("claimwr9.busy_hold", 32'(if_a.rd_busy[1]), 32'd1);

    // Both ports on one address.
    rd_addr = {5'd7, 5'd7};
    cycle("same_addr7");

    rd_addr = {5'd9, 5'd3};
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0001;
    cycle("wr3");
    cycle("wr3_after");

    // Async reset while ready: outputs drop without a clock edge.
    #2;
    rst_n = 1'b0;
    m_ready = 1'b0;
    model_clear();
    #1;
    chk("rst2.ready", 32'(if_a.ready), '0);
    chk("rst2.busy9", 32'(if_a.rd_busy[1]), '0);
    chk("rst2.x3", if_a.rd_data[XL-1:0], '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    chk("clr2.ready_at_cnt15", 32'(if_a.ready), '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst3.ready", 32'(if_a.ready), '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_clear("clr3", 1'b0);

    rd_addr = {5'd9, 5'd3};
    cycle("post_rst");
    chk("post_rst.ready", 32'(if_a.ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
